// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory boot/load controller.
// Contents: controller state enum, default byte/word geometry, and the
// byte-count width helper used to size the accepted-byte counter.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_e;

  localparam int unsigned DEF_MEM_WIDTH  = 8;
  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_WORD_WIDTH / DEF_MEM_WIDTH;

  // Counter must hold the value MEM_DEPTH itself (a completely full memory).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader byte-stream handshake between an external loader (UART/bench) and
// the boot controller.
// Signals: ld_valid/ld_data/ld_last from the loader, ld_ready back from the
// controller. master = loader side, slave = controller side.
interface imem_boot_ctrl_if #(
  parameter int unsigned MEM_WIDTH = 8
);

  logic                 ld_valid;
  logic [MEM_WIDTH-1:0] ld_data;
  logic                 ld_last;
  logic                 ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);

endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller for the byte-organised MIPS instruction memory.
// Accepts a byte image over the loader handshake, writes it through a
// registered byte write port, holds/flushes the pipeline while loading,
// then pulses pc_reset and releases the core. Supports reload from RUN and
// flags overflow or non-word-multiple images.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   boot_start           one-cycle (re)load request
//   ld                   loader handshake (slave side)
//   mem_we/waddr/wdata   registered byte write port
//   if_flush, cpu_hold   decoded from state: asserted unless running
//   pc_reset             one-cycle pulse in the final FLUSH cycle
//   load_done, load_err  load status
//   byte_count           bytes accepted in the current load
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH    = 8,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned ADDR_SIZE    = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          boot_start,
  imem_boot_ctrl_if.slave               ld,
  output logic                          mem_we,
  output logic [ADDR_SIZE-1:0]          mem_waddr,
  output logic [MEM_WIDTH-1:0]          mem_wdata,
  output logic                          if_flush,
  output logic                          cpu_hold,
  output logic                          pc_reset,
  output logic                          load_done,
  output logic                          load_err,
  output logic [cnt_width(MEM_DEPTH)-1:0] byte_count
);

  localparam int unsigned CW  = cnt_width(MEM_DEPTH);
  localparam int unsigned BPW = WORD_WIDTH / MEM_WIDTH;
  localparam int unsigned FW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_e        state;
  logic [FW-1:0] flush_cnt;
  logic          hs;
  logic [CW-1:0] next_count;
  logic          mem_full;

  // State-decoded controls: core is held and fetch flushed unless running.
  assign ld.ld_ready = (state == LOAD);
  assign cpu_hold    = (state != RUN);
  assign if_flush    = (state != RUN);

  assign hs         = ld.ld_valid & ld.ld_ready;
  assign next_count = byte_count + CW'(1);
  assign mem_full   = (32'(byte_count) >= MEM_DEPTH);

  // Controller FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      pc_reset   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      pc_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (boot_start) begin
            state      <= LOAD;
            byte_count <= '0;
          end
        end
        LOAD: begin
          // A restart wins over a same-cycle handshake; that byte is dropped.
          if (boot_start) begin
            byte_count <= '0;
          end else if (hs) begin
            if (!mem_full) begin
              mem_we     <= 1'b1;
              mem_waddr  <= ADDR_SIZE'(byte_count);
              mem_wdata  <= ld.ld_data;
              byte_count <= next_count;
              if (ld.ld_last) begin
                if ((32'(next_count) % BPW) == 0) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
                  pc_reset  <= (FLUSH_CYCLES == 1);
                end else begin
                  state    <= ERROR;
                  load_err <= 1'b1;
                end
              end
            end else begin
              // Overflow: byte consumed without a write.
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= RUN;
            load_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
            pc_reset  <= ((flush_cnt + FW'(1)) == FLUSH_LAST);
          end
        end
        RUN: begin
          if (boot_start) begin
            state      <= LOAD;
            byte_count <= '0;
            load_done  <= 1'b0;
          end
        end
        ERROR: begin
          if (boot_start) begin
            state      <= LOAD;
            byte_count <= '0;
            load_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
